// File: rtl/control_unit.sv
// rtl/control_unit.sv - instruction sequencer: stage strobes and program-counter commands
module control_unit #(
    localparam int CONTROL_BIT_MAX = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     en_mem,
    input  logic                     mem_wait,
    input  logic                     should_branch,
    input  logic                     imm,
    output logic [CONTROL_BIT_MAX:0] control_o,
    output logic [1:0]               pc_op
);

    localparam int BIT_FETCH    = 0;
    localparam int BIT_DECODE   = 1;
    localparam int BIT_REG_RD   = 2;
    localparam int BIT_ALU      = 3;
    localparam int BIT_MEM      = 4;
    localparam int BIT_REG_WR   = 5;
    localparam int BIT_PC_DELAY = 6;

    localparam logic [1:0] PC_NOP    = 2'b00;
    localparam logic [1:0] PC_INC    = 2'b01;
    localparam logic [1:0] PC_ASSIGN = 2'b10;
    localparam logic [1:0] PC_RESET  = 2'b11;

    // Encoding 3'd7 is unused; reaching it is a fault and recovers to FETCH.
    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_REG_RD   = 3'd2,
        S_ALU      = 3'd3,
        S_MEM      = 3'd4,
        S_REG_WR   = 3'd5,
        S_PC_DELAY = 3'd6
    } state_t;

    state_t state;
    state_t state_next;
    logic [CONTROL_BIT_MAX:0] ctl_dec;
    logic [1:0]               pc_dec;

    // State register; reset drops any in-flight instruction back to FETCH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: frozen when en is low, otherwise walk the pipeline stages.
    always_comb begin
        state_next = state;
        if (en) begin
            case (state)
                S_FETCH:    state_next = S_DECODE;
                S_DECODE:   state_next = S_REG_RD;
                S_REG_RD:   state_next = S_ALU;
                S_ALU:      state_next = en_mem ? S_MEM : S_REG_WR;
                S_MEM:      state_next = mem_wait ? S_MEM : S_REG_WR;
                S_REG_WR:   state_next = S_PC_DELAY;
                S_PC_DELAY: state_next = S_FETCH;
                default:    state_next = S_FETCH;
            endcase
        end
    end

    // Stage strobe decoded purely from the state register.
    always_comb begin
        ctl_dec = '0;
        case (state)
            S_FETCH:    ctl_dec[BIT_FETCH]    = 1'b1;
            S_DECODE:   ctl_dec[BIT_DECODE]   = 1'b1;
            S_REG_RD:   ctl_dec[BIT_REG_RD]   = 1'b1;
            S_ALU:      ctl_dec[BIT_ALU]      = 1'b1;
            S_MEM:      ctl_dec[BIT_MEM]      = 1'b1;
            S_REG_WR:   ctl_dec[BIT_REG_WR]   = 1'b1;
            S_PC_DELAY: ctl_dec[BIT_PC_DELAY] = 1'b1;
            default:    ctl_dec = '0;
        endcase
    end

    // PC command: bump past an immediate in DECODE, branch or step in REG_WR.
    always_comb begin
        pc_dec = PC_NOP;
        if (en) begin
            case (state)
                S_DECODE: pc_dec = imm ? PC_INC : PC_NOP;
                S_REG_WR: pc_dec = should_branch ? PC_ASSIGN : PC_INC;
                default:  pc_dec = PC_NOP;
            endcase
        end
    end

    // While reset is held the strobes are blanked and the PC is told to reset.
    always_comb begin
        control_o = ctl_dec;
        pc_op     = pc_dec;
        if (!rst) begin
            control_o = '0;
            pc_op     = PC_RESET;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for control_unit
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       en_mem;
    logic       mem_wait;
    logic       should_branch;
    logic       imm;
    logic [6:0] control_o;
    logic [1:0] pc_op;

    int n_cmp = 0;
    int n_mis = 0;

    control_unit dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .en_mem        (en_mem),
        .mem_wait      (mem_wait),
        .should_branch (should_branch),
        .imm           (imm),
        .control_o     (control_o),
        .pc_op         (pc_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input logic [6:0] ctl, input logic [1:0] pc);
        #1;
        check({tag, "/ctl"}, {1'b0, control_o}, {1'b0, ctl});
        check({tag, "/pc"},  {6'b0, pc_op},     {6'b0, pc});
    endtask

    // Walk one instruction from FETCH back to FETCH, checking every stage.
    task automatic run_instr(input logic em, input int n, input logic im, input logic br);
        imm = im;
        expect_out("fetch", 7'h01, 2'b00);
        step();
        expect_out("decode", 7'h02, im ? 2'b01 : 2'b00);
        step();
        en_mem = em;
        expect_out("reg_rd", 7'h04, 2'b00);
        step();
        expect_out("alu", 7'h08, 2'b00);
        step();
        if (em) begin
            for (int i = 0; i <= n; i++) begin
                mem_wait = (i < n);
                expect_out("mem", 7'h10, 2'b00);
                step();
            end
        end
        mem_wait      = 1'b0;
        should_branch = br;
        expect_out("reg_wr", 7'h20, br ? 2'b10 : 2'b01);
        step();
        expect_out("pc_delay", 7'h40, 2'b00);
        step();
    endtask

    // Drive inputs reactively from the observed stage and measure the length.
    task automatic measure(input logic em, input int n, input logic im, input logic br);
        int cnt;
        int waits;
        cnt   = 0;
        waits = 0;
        imm           = im;
        en_mem        = em;
        should_branch = br;
        do begin
            mem_wait = (control_o == 7'h10) && (waits < n);
            if (control_o == 7'h10) waits++;
            #1;
            check("onehot", {7'b0, $onehot(control_o)}, 8'd1);
            step();
            cnt++;
        end while (control_o != 7'h01 && cnt < 40);
        mem_wait = 1'b0;
        check("instr_len", cnt[7:0], em ? 8'(7 + n) : 8'd6);
    endtask

    initial begin
        rst           = 1'b0;
        en            = 1'b1;
        en_mem        = 1'b0;
        mem_wait      = 1'b0;
        should_branch = 1'b0;
        imm           = 1'b0;

        // reset visible before any clock edge, and across one
        #1;
        expect_out("rst_noclk", 7'h00, 2'b11);
        step();
        expect_out("rst_held", 7'h00, 2'b11);
        rst = 1'b1;
        expect_out("rst_release", 7'h01, 2'b00);

        // plain instruction, immediate + branch, then neither, then memory with 3 waits
        run_instr(1'b0, 0, 1'b1, 1'b1);
        run_instr(1'b0, 0, 1'b0, 1'b0);
        run_instr(1'b1, 3, 1'b0, 1'b0);
        run_instr(1'b1, 0, 1'b1, 1'b0);

        // enable low: DECODE suppresses pc_op, ALU holds for 5 cycles
        imm = 1'b1;
        step();
        en = 1'b0;
        expect_out("dec_hold", 7'h02, 2'b00);
        en = 1'b1;
        step();
        en_mem = 1'b1;
        step();
        en       = 1'b0;
        mem_wait = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_out("alu_hold", 7'h08, 2'b00);
        end
        en       = 1'b1;
        en_mem   = 1'b0;
        mem_wait = 1'b0;
        step();
        should_branch = 1'b0;
        expect_out("resume_wr", 7'h20, 2'b01);
        step();
        step();
        expect_out("resume_fetch", 7'h01, 2'b00);

        // mixed instruction stream, one-hot and length checked every cycle
        measure(1'b0, 0, 1'b1, 1'b0);
        measure(1'b1, 2, 1'b0, 1'b1);
        measure(1'b1, 0, 1'b1, 1'b1);
        measure(1'b0, 0, 1'b0, 1'b0);

        // en low beats mem_wait=0 in MEM, then reset aborts a waiting MEM
        en_mem = 1'b1;
        step();
        step();
        step();
        step();
        en       = 1'b0;
        mem_wait = 1'b0;
        step();
        expect_out("mem_hold", 7'h10, 2'b00);
        en       = 1'b1;
        mem_wait = 1'b1;
        step();
        expect_out("mem_wait", 7'h10, 2'b00);
        #2;
        rst = 1'b0;
        expect_out("rst_mid", 7'h00, 2'b11);
        @(negedge clk);
        expect_out("rst_mid_held", 7'h00, 2'b11);
        rst      = 1'b1;
        mem_wait = 1'b0;
        en_mem   = 1'b0;
        imm      = 1'b0;
        expect_out("rst_mid_rel", 7'h01, 2'b00);
        step();
        expect_out("rst_mid_dec", 7'h02, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
